// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter and access sequencer placing two read/write clients in front of
// a single-port RAM. Each access is IDLE -> ACCESS -> DONE, one cycle per state.
module ram_arbiter_2p #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic              ram_cs,
    output logic              ram_re,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_q, last_d;
    logic                sel_q, sel_d;
    logic                op_we_q, op_we_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                ram_cs_q, ram_cs_d;
    logic                ram_re_q, ram_re_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                busy_q, busy_d;

    logic                win;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;

    // Winner selection: a lone requester wins, contention goes to the port that did not win last.
    always_comb begin
        win      = 1'b0;
        win_we   = 1'b0;
        win_addr = '0;
        win_data = '0;
        if (req0 && req1) begin
            win = ~last_q;
        end else begin
            win = req1;
        end
        win_we   = win ? we1 : we0;
        win_addr = win ? addr1 : addr0;
        win_data = win ? wdata1 : wdata0;
    end

    // Next-state and registered-output logic; strobes, grants and valids are single-cycle pulses.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        sel_d      = sel_q;
        op_we_d    = op_we_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        ram_cs_d   = 1'b0;
        ram_re_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    sel_d      = win;
                    last_d     = win;
                    op_we_d    = win_we;
                    ram_cs_d   = 1'b1;
                    ram_we_d   = win_we;
                    ram_re_d   = ~win_we;
                    ram_addr_d = win_addr;
                    ram_din_d  = win_data;
                    gnt0_d     = ~win;
                    gnt1_d     = win;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                state_d = DONE;
            end
            DONE: begin
                // RAM read data is valid during DONE, one cycle after the access edge.
                if (!op_we_q) begin
                    if (sel_q) begin
                        rdata1_d  = ram_dout;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = ram_dout;
                        rvalid0_d = 1'b1;
                    end
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            sel_q      <= 1'b0;
            op_we_q    <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            ram_cs_q   <= 1'b0;
            ram_re_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            sel_q      <= sel_d;
            op_we_q    <= op_we_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            ram_cs_q   <= ram_cs_d;
            ram_re_q   <= ram_re_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign ram_cs   = ram_cs_q;
    assign ram_re   = ram_re_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Bench for ram_arbiter_2p: a RAM model, two clients replaying op queues, and a
// transaction-level predictor of grant order and read data.
module tb_ram_arbiter_2p;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 4;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } op_t;

    typedef struct {
        int            port;
        op_t           op;
        logic [DW-1:0] rdata;
    } exp_t;

    typedef struct {
        int            port;
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        bit            cs_ok;
    } obs_t;

    typedef struct {
        int            port;
        int            cyc;
        logic [DW-1:0] data;
    } rv_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ram_cs, ram_re, ram_we, busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cs_cycles = 0;
    int dual_gnt = 0;
    int start_cyc = 0;

    op_t  q0[$];
    op_t  q1[$];
    exp_t exp_q[$];
    obs_t obs_q[$];
    rv_t  rv_q[$];

    logic [DW-1:0] mem [16];
    logic [DW-1:0] ref_mem [16];
    logic          ref_last = 1'b1;
    bit            mem_clr = 1'b1;

    ram_arbiter_2p #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
        .ram_cs(ram_cs), .ram_re(ram_re), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM: acts on the rising edge with cs high, read data appears the next cycle.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            ram_dout <= '0;
        end else if (ram_cs && ram_we) begin
            mem[ram_addr] <= ram_din;
        end else if (ram_cs && ram_re) begin
            ram_dout <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (gnt0 && gnt1) dual_gnt++;
        if (ram_cs) cs_cycles++;
        if (gnt0 || gnt1)
            obs_q.push_back('{gnt1 ? 1 : 0, cyc, ram_we, ram_addr, ram_din,
                              ram_cs && (ram_re == !ram_we)});
        if (rvalid0) rv_q.push_back('{0, cyc, rdata0});
        if (rvalid1) rv_q.push_back('{1, cyc, rdata1});
    end

    function automatic op_t mk(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        op_t o;
        o.we   = we;
        o.addr = addr;
        o.data = data;
        return o;
    endfunction

    // Expected transaction order: requests are held continuously, contention alternates.
    function automatic void predict(input op_t p0[$], input op_t p1[$]);
        exp_t e;
        int   w;
        exp_q.delete();
        while (p0.size() > 0 || p1.size() > 0) begin
            if (p0.size() > 0 && p1.size() > 0) w = (ref_last == 1'b0) ? 1 : 0;
            else w = (p0.size() > 0) ? 0 : 1;
            e.port  = w;
            e.op    = (w == 1) ? p1.pop_front() : p0.pop_front();
            e.rdata = '0;
            if (e.op.we) ref_mem[e.op.addr] = e.op.data;
            else e.rdata = ref_mem[e.op.addr];
            ref_last = (w == 1);
            exp_q.push_back(e);
        end
    endfunction

    function automatic void drive();
        if (q0.size() > 0) begin
            req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data;
        end else begin
            req0 = 1'b0;
        end
        if (q1.size() > 0) begin
            req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data;
        end else begin
            req1 = 1'b0;
        end
    endfunction

    // Clients advance to their next op when granted; returns once both queues drained and settled.
    task automatic serve(input int budget, output bit timed_out);
        int idle_cnt;
        idle_cnt  = 0;
        timed_out = 1'b1;
        obs_q.delete();
        rv_q.delete();
        cs_cycles = 0;
        dual_gnt  = 0;
        start_cyc = cyc;
        drive();
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (gnt0 && q0.size() > 0) void'(q0.pop_front());
            if (gnt1 && q1.size() > 0) void'(q1.pop_front());
            drive();
            if (q0.size() == 0 && q1.size() == 0) begin
                idle_cnt++;
                if (idle_cnt >= 4) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        ref_last = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, ram_cs, ram_re, ram_we, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 00000000",
                     {gnt0, gnt1, rvalid0, rvalid1, ram_cs, ram_re, ram_we, busy});
        end
        checks++;
        if (ram_addr !== 4'h0 || ram_din !== 4'h0) begin
            errors++;
            $display("FAIL reset_ram_bus got addr=%h din=%h want 0 0", ram_addr, ram_din);
        end
        checks++;
        if (rdata0 !== 4'h0 || rdata1 !== 4'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h %h want 0 0", rdata0, rdata1);
        end
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        mem_clr  = 1'b0;
        rst      = 1'b0;
        ref_last = 1'b1;
    endtask

    task automatic test_write_read();
        bit to;
        do_reset();
        q0.push_back(mk(1'b1, 4'd3, 4'b1010));
        q0.push_back(mk(1'b0, 4'd3, 4'd0));
        predict(q0, q1);
        serve(40, to);
        checks++;
        if (to || obs_q.size() != 2 || rv_q.size() != 1) begin
            errors++;
            $display("FAIL wr_rd_count got timeout=%0d grants=%0d rvalids=%0d want 0 2 1",
                     to, obs_q.size(), rv_q.size());
        end else begin
            checks++;
            if (obs_q[0].port != 0 || obs_q[0].cyc != start_cyc + 1) begin
                errors++;
                $display("FAIL wr_gnt got port=%0d cyc=%0d want 0 %0d",
                         obs_q[0].port, obs_q[0].cyc, start_cyc + 1);
            end
            checks++;
            if (obs_q[0].we !== 1'b1 || obs_q[0].addr !== 4'd3 || obs_q[0].din !== 4'b1010 || !obs_q[0].cs_ok) begin
                errors++;
                $display("FAIL wr_strobe got we=%b addr=%h din=%b cs_ok=%0d want 1 3 1010 1",
                         obs_q[0].we, obs_q[0].addr, obs_q[0].din, obs_q[0].cs_ok);
            end
            checks++;
            if (cs_cycles != 2) begin
                errors++;
                $display("FAIL wr_rd_strobe_len got %0d want 2", cs_cycles);
            end
            checks++;
            if (obs_q[1].port != 0 || obs_q[1].we !== 1'b0 || obs_q[1].cyc != obs_q[0].cyc + 3) begin
                errors++;
                $display("FAIL rd_gnt got port=%0d we=%b cyc=%0d want 0 0 %0d",
                         obs_q[1].port, obs_q[1].we, obs_q[1].cyc, obs_q[0].cyc + 3);
            end
            checks++;
            if (rv_q[0].port != 0 || rv_q[0].data !== 4'b1010 || rv_q[0].cyc != obs_q[1].cyc + 2) begin
                errors++;
                $display("FAIL rd_rvalid got port=%0d data=%b cyc=%0d want 0 1010 %0d",
                         rv_q[0].port, rv_q[0].data, rv_q[0].cyc, obs_q[1].cyc + 2);
            end
        end
        checks++;
        if (rdata0 !== 4'b1010 || rdata1 !== 4'h0) begin
            errors++;
            $display("FAIL rd_hold got rdata0=%b rdata1=%b want 1010 0000", rdata0, rdata1);
        end
    endtask

    task automatic test_both_from_reset();
        bit to;
        do_reset();
        q0.push_back(mk(1'b1, 4'd0, 4'b0101));
        q0.push_back(mk(1'b0, 4'd0, 4'd0));
        q1.push_back(mk(1'b1, 4'd15, 4'b1111));
        q1.push_back(mk(1'b0, 4'd15, 4'd0));
        predict(q0, q1);
        serve(60, to);
        checks++;
        if (to || obs_q.size() != 4 || rv_q.size() != 2) begin
            errors++;
            $display("FAIL both_count got timeout=%0d grants=%0d rvalids=%0d want 0 4 2",
                     to, obs_q.size(), rv_q.size());
        end else begin
            checks++;
            if (obs_q[0].port != 0 || obs_q[1].port != 1 || obs_q[1].cyc != obs_q[0].cyc + 3) begin
                errors++;
                $display("FAIL both_order got %0d,%0d gap=%0d want 0,1 gap=3",
                         obs_q[0].port, obs_q[1].port, obs_q[1].cyc - obs_q[0].cyc);
            end
            checks++;
            if (obs_q[1].addr !== 4'd15 || obs_q[1].din !== 4'b1111) begin
                errors++;
                $display("FAIL both_addr15 got addr=%h din=%b want f 1111", obs_q[1].addr, obs_q[1].din);
            end
            checks++;
            if (rv_q[0].port != 0 || rv_q[0].data !== 4'b0101 || rv_q[1].port != 1 || rv_q[1].data !== 4'b1111) begin
                errors++;
                $display("FAIL both_readback got p%0d=%b p%0d=%b want p0=0101 p1=1111",
                         rv_q[0].port, rv_q[0].data, rv_q[1].port, rv_q[1].data);
            end
        end
        checks++;
        if (dual_gnt != 0) begin
            errors++;
            $display("FAIL both_dual_gnt got %0d want 0", dual_gnt);
        end
    endtask

    task automatic test_contention();
        bit to;
        for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, 4'($urandom_range(0, 15)), 4'd0));
        for (int i = 0; i < 4; i++) q1.push_back(mk(1'b0, 4'($urandom_range(0, 15)), 4'd0));
        predict(q0, q1);
        serve(80, to);
        checks++;
        if (to || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL cont_count got timeout=%0d grants=%0d want 0 %0d", to, obs_q.size(), exp_q.size());
        end else begin
            int k = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i].port != (i % 2) || obs_q[i].port != exp_q[i].port ||
                    obs_q[i].addr !== exp_q[i].op.addr || obs_q[i].we !== 1'b0 || !obs_q[i].cs_ok) begin
                    errors++;
                    $display("FAIL cont_grant[%0d] got port=%0d addr=%h we=%b want %0d %h 0",
                             i, obs_q[i].port, obs_q[i].addr, obs_q[i].we, i % 2, exp_q[i].op.addr);
                end
                if (i > 0) begin
                    checks++;
                    if (obs_q[i].cyc != obs_q[i-1].cyc + 3) begin
                        errors++;
                        $display("FAIL cont_gap[%0d] got %0d want 3", i, obs_q[i].cyc - obs_q[i-1].cyc);
                    end
                end
                checks++;
                if (k >= rv_q.size() || rv_q[k].port != exp_q[i].port ||
                    rv_q[k].data !== exp_q[i].rdata || rv_q[k].cyc != obs_q[i].cyc + 2) begin
                    errors++;
                    $display("FAIL cont_read[%0d] got rvalids=%0d want port=%0d data=%h", i, rv_q.size(),
                             exp_q[i].port, exp_q[i].rdata);
                end
                k++;
            end
            checks++;
            if (rv_q.size() != k) begin
                errors++;
                $display("FAIL cont_rvalid_count got %0d want %0d", rv_q.size(), k);
            end
        end
    endtask

    task automatic test_coherency();
        bit to;
        q1.push_back(mk(1'b1, 4'd7, 4'b0011));
        predict(q0, q1);
        serve(30, to);
        q0.push_back(mk(1'b0, 4'd7, 4'd0));
        predict(q0, q1);
        serve(30, to);
        checks++;
        if (to || rv_q.size() != 1 || obs_q.size() != 1) begin
            errors++;
            $display("FAIL coh_count got timeout=%0d grants=%0d rvalids=%0d want 0 1 1", to, obs_q.size(), rv_q.size());
        end else begin
            checks++;
            if (rv_q[0].port != 0 || rv_q[0].data !== 4'b0011 || rdata0 !== 4'b0011) begin
                errors++;
                $display("FAIL coh_data got port=%0d data=%b rdata0=%b want 0 0011", rv_q[0].port, rv_q[0].data, rdata0);
            end
        end
    endtask

    task automatic test_random();
        bit to;
        int n0, n1;
        for (int it = 0; it < 20; it++) begin
            n0 = $urandom_range(1, 4);
            n1 = $urandom_range(0, 4);
            for (int i = 0; i < n0; i++)
                q0.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))));
            for (int i = 0; i < n1; i++)
                q1.push_back(mk(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))));
            predict(q0, q1);
            serve(3 * (n0 + n1) + 20, to);
            checks++;
            if (to || obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rnd_count[%0d] got timeout=%0d grants=%0d want 0 %0d",
                         it, to, obs_q.size(), exp_q.size());
            end else begin
                int k = 0;
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (obs_q[i].port != exp_q[i].port || obs_q[i].we !== exp_q[i].op.we ||
                        obs_q[i].addr !== exp_q[i].op.addr || !obs_q[i].cs_ok ||
                        (exp_q[i].op.we && obs_q[i].din !== exp_q[i].op.data) ||
                        (i > 0 && obs_q[i].cyc != obs_q[i-1].cyc + 3)) begin
                        errors++;
                        $display("FAIL rnd_grant[%0d.%0d] got port=%0d we=%b addr=%h din=%h want %0d %b %h %h",
                                 it, i, obs_q[i].port, obs_q[i].we, obs_q[i].addr, obs_q[i].din,
                                 exp_q[i].port, exp_q[i].op.we, exp_q[i].op.addr, exp_q[i].op.data);
                    end
                    if (!exp_q[i].op.we) begin
                        checks++;
                        if (k >= rv_q.size() || rv_q[k].port != exp_q[i].port ||
                            rv_q[k].data !== exp_q[i].rdata || rv_q[k].cyc != obs_q[i].cyc + 2) begin
                            errors++;
                            $display("FAIL rnd_read[%0d.%0d] got rvalids=%0d want port=%0d data=%h",
                                     it, i, rv_q.size(), exp_q[i].port, exp_q[i].rdata);
                        end
                        k++;
                    end
                end
                checks++;
                if (rv_q.size() != k) begin
                    errors++;
                    $display("FAIL rnd_rvalid_count[%0d] got %0d want %0d", it, rv_q.size(), k);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        bit to;
        do_reset();
        q0.push_back(mk(1'b0, 4'd3, 4'd0));
        drive();
        for (int c = 0; c < 10 && !gnt0; c++) @(negedge clk);
        checks++;
        if (!gnt0 || !ram_cs || !ram_re) begin
            errors++;
            $display("FAIL mid_setup got gnt0=%b cs=%b re=%b want 1 1 1", gnt0, ram_cs, ram_re);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (ram_cs !== 1'b0 || ram_re !== 1'b0 || gnt0 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_async got cs=%b re=%b gnt0=%b busy=%b want 0 0 0 0", ram_cs, ram_re, gnt0, busy);
        end
        q0.delete();
        req0 = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        ref_last = 1'b1;
        q1.push_back(mk(1'b0, 4'd3, 4'd0));
        predict(q0, q1);
        serve(30, to);
        checks++;
        if (to || obs_q.size() != 1 || obs_q[0].port != 1 || obs_q[0].cyc != start_cyc + 1) begin
            errors++;
            $display("FAIL mid_next_gnt got timeout=%0d grants=%0d want one port-1 grant at %0d",
                     to, obs_q.size(), start_cyc + 1);
        end
        checks++;
        if (rv_q.size() != 1 || rv_q[0].port != 1 || rv_q[0].data !== exp_q[0].rdata) begin
            errors++;
            $display("FAIL mid_rvalid got rvalids=%0d want single port-1 read of %h", rv_q.size(), exp_q[0].rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_both_from_reset();
        test_contention();
        test_coherency();
        test_random();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter_2p.md
Name: ram_arbiter_2p

Overview:
- Two-requester arbiter/sequencer in front of the 16x4 single-port RAM (`ram_16x4`).
- Accepts independent read/write requests from port 0 and port 1 and picks one round-robin.
- Drives the RAM strobes (chip select, read/write enable, address, data) with fixed timing and returns read data to the winning port with a one-cycle valid pulse.
- Sits between client logic and the RAM; the RAM is never driven directly by clients.

Parameters:
- ADDR_W, 4, address width (RAM depth 2^ADDR_W = 16).
- DATA_W, 4, data word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request.
- we0  in  1  port 0 op: 1 = write, 0 = read.
- addr0  in  ADDR_W  port 0 address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 grant.
- rdata0  out  DATA_W  port 0 read data.
- rvalid0  out  1  port 0 read data valid.
- req1, we1, addr1, wdata1, gnt1, rdata1, rvalid1: same as port 0, for port 1.
- ram_cs  out  1  RAM chip_select.
- ram_re  out  1  RAM read_enable.
- ram_we  out  1  RAM write_enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM d_in.
- ram_dout  in  DATA_W  RAM d_out.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- RAM contract:
  - RAM acts on the rising edge where cs and (we or re) are high.
  - For a read, ram_dout is valid in the cycle after that edge.
- All outputs are registered.
- On rst, asynchronously:
  - state = IDLE.
  - All gnt, rvalid, ram_cs, ram_re, ram_we = 0.
  - ram_addr, ram_din, rdata0, rdata1 = 0.
  - Round-robin pointer last = 1, so port 0 wins the first contention.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - req0/req1 are sampled only in IDLE.
  - If any request is high, pick a winner:
    - Only one requester: it wins.
    - Both requesters: the port != last wins.
  - On the edge, latch the winner's we/addr/wdata, set ram_cs = 1, set ram_we = we_x and ram_re = ~we_x, set ram_addr/ram_din, set gnt_x = 1, set last = winner, go to ACCESS.
  - With no request, stay in IDLE with strobes low.
- ACCESS:
  - Lasts exactly one cycle: strobes and gnt_x are high, and the RAM performs the operation on the edge ending ACCESS.
  - On that edge, clear ram_cs/ram_re/ram_we and gnt_x (ram_addr and ram_din hold their value) and go to DONE.
- DONE:
  - Lasts one cycle.
  - For a read, on the edge ending DONE: rdata_x <= ram_dout and rvalid_x <= 1.
  - Go to IDLE.
- rvalid_x:
  - High for exactly one cycle (the first IDLE cycle after DONE); rdata_x holds until the next read by that port.
  - Writes never assert rvalid.
- Timing, with a request sampled at edge E0:
  - gnt high in cycle E0..E1.
  - RAM op at E1.
  - rvalid high in E2..E3.
  - One access per 3 cycles maximum throughput.
  - A new request can be sampled at E3, the same edge that ends rvalid.
- Handshake:
  - A requester holds req and its fields stable until it sees gnt, then drops req before the next IDLE.
  - A req still high in IDLE after a grant is treated as a new request.
- Simultaneous requests: the ports alternate strictly. With both held continuously, the grant order is 0, 1, 0, 1, ...
- A request arriving during ACCESS/DONE waits; it is not lost if held.
- A write followed by a read to the same address returns the new data (operations are serialized).
- Address 0 and 15 have no special handling; the address is passed through with no wrap or arithmetic.
- Reset during ACCESS or DONE:
  - The operation is abandoned and strobes drop immediately (async).
  - No gnt or rvalid is asserted afterwards.
  - RAM contents at that address are undefined if reset coincides with the write edge.

Test Plan:
- Reset: hold rst 2 cycles -> all strobes/gnt/rvalid 0, busy 0, rdata0 = rdata1 = 0.
- Port 0 writes 4'b1010 to addr 3, then reads addr 3 -> gnt0 one cycle after req0 sampled, ram_we pulse of 1 cycle with ram_addr = 3, ram_din = 1010; on the read, rvalid0 pulses 2 cycles after gnt0 with rdata0 = 1010, and rvalid1 stays 0.
- Both ports request from reset: req0 (write addr 0 = 0101) and req1 (write addr 15 = 1111) held -> gnt0 first, gnt1 3 cycles later. Read-back of addr 0 and 15 returns 0101 and 1111.
- Continuous contention with 4 reads per port -> strict 0, 1, 0, 1 grant alternation, no port starved, each rvalid on the correct port.
- Cross-port coherency: port 1 writes addr 7 = 0011, then port 0 reads addr 7 -> rdata0 = 0011.
- Reset mid-ACCESS (port 0 read addr 3) -> ram_cs/ram_re drop without waiting for an edge, no rvalid0, state IDLE. The next req1 is granted immediately after reset.
